// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command reader.
// Move-bit offset helpers are also used by the solver's offset logic.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE,
      V_ISSUE,
      V_WAIT,
      H_ISSUE,
      H_WAIT
   } state_t;

   localparam logic [7:0] HEAD_N = 8'h00;
   localparam logic [7:0] HEAD_W = 8'h3F;
   localparam logic [7:0] HEAD_S = 8'h7F;
   localparam logic [7:0] HEAD_E = 8'hBF;

   localparam int         NUM_MOVES_DEF  = 24;
   localparam logic [3:0] MOVE_OP_DEF    = 4'h2;
   localparam logic [3:0] FANFARE_OP_DEF = 4'h3;

   // +x = east, +y = north
   function automatic logic signed [2:0] move_dx(input logic [2:0] b);
      case (b)
         3'd0:    return -3'sd1;
         3'd1:    return  3'sd1;
         3'd2:    return -3'sd2;
         3'd3:    return -3'sd2;
         3'd4:    return -3'sd1;
         3'd5:    return  3'sd1;
         3'd6:    return  3'sd2;
         default: return  3'sd2;
      endcase
   endfunction

   function automatic logic signed [2:0] move_dy(input logic [2:0] b);
      case (b)
         3'd0:    return  3'sd2;
         3'd1:    return  3'sd2;
         3'd2:    return  3'sd1;
         3'd3:    return -3'sd1;
         3'd4:    return -3'sd2;
         3'd5:    return -3'sd2;
         3'd6:    return -3'sd1;
         default: return  3'sd1;
      endcase
   endfunction

   function automatic logic [3:0] abs_len(input logic signed [2:0] d);
      logic signed [2:0] m;
      m = (d < 3'sd0) ? -d : d;
      return {1'b0, m};
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical and a horizontal leg.
// Anything that is not exactly one-hot decodes to two zero-length legs heading N.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] v_heading,
   output logic [3:0] v_len,
   output logic [7:0] h_heading,
   output logic [3:0] h_len
);

   logic one_hot;
   logic signed [2:0] dx;
   logic signed [2:0] dy;

   assign one_hot = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

   always_comb begin
      dx        = 3'sd0;
      dy        = 3'sd0;
      v_heading = HEAD_N;
      v_len     = 4'd0;
      h_heading = HEAD_N;
      h_len     = 4'd0;
      if (one_hot) begin
         for (int i = 0; i < 8; i++) begin
            if (move[i]) begin
               dx = move_dx(3'(i));
               dy = move_dy(3'(i));
            end
         end
         v_heading = (dy > 3'sd0) ? HEAD_N : HEAD_S;
         v_len     = abs_len(dy);
         h_heading = (dx > 3'sd0) ? HEAD_E : HEAD_W;
         h_len     = abs_len(dx);
      end
   end

endmodule

// File: rtl/tour_cmd.sv
// Reads the solved tour move by move and issues vertical then horizontal leg commands.
// Build option TOUR_CMD_FANFARE_EN: horizontal legs carry the fanfare opcode.
//
// state   | meaning
// IDLE    | UART commands pass straight through; wait for start_tour
// V_ISSUE | latch vertical leg of move[indx], raise cmd_rdy
// V_WAIT  | handshake vertical leg until send_resp with cmd_rdy low
// H_ISSUE | latch horizontal leg of move[indx], raise cmd_rdy
// H_WAIT  | handshake horizontal leg; then next move or finish
module tour_cmd
   import tour_pkg::*;
#(
   parameter int         NUM_MOVES = NUM_MOVES_DEF,
   parameter logic [3:0] MOVE_OP   = MOVE_OP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        tour_done
);

`ifdef TOUR_CMD_FANFARE_EN
   localparam logic [3:0] H_OP = FANFARE_OP_DEF;
`else
   localparam logic [3:0] H_OP = MOVE_OP;
`endif

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   state_t      state;
   logic [15:0] cmd_reg;
   logic        cmd_rdy_reg;
   logic [7:0]  v_heading;
   logic [3:0]  v_len;
   logic [7:0]  h_heading;
   logic [3:0]  h_len;
   logic        leg_done;

   tour_move_decode u_decode (
      .move      (move),
      .v_heading (v_heading),
      .v_len     (v_len),
      .h_heading (h_heading),
      .h_len     (h_len)
   );

   // a clear in the same cycle as send_resp counts as cmd_rdy already low
   assign leg_done = send_resp && (!cmd_rdy_reg || clr_cmd_rdy);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         indx        <= 5'd0;
         cmd_reg     <= 16'h0000;
         cmd_rdy_reg <= 1'b0;
         tour_done   <= 1'b0;
      end else begin
         tour_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_tour) begin
                  indx  <= 5'd0;
                  state <= V_ISSUE;
               end
            end
            V_ISSUE: begin
               cmd_reg     <= {MOVE_OP, v_heading, v_len};
               cmd_rdy_reg <= 1'b1;
               state       <= V_WAIT;
            end
            V_WAIT: begin
               if (clr_cmd_rdy) cmd_rdy_reg <= 1'b0;
               if (leg_done) state <= H_ISSUE;
            end
            H_ISSUE: begin
               cmd_reg     <= {H_OP, h_heading, h_len};
               cmd_rdy_reg <= 1'b1;
               state       <= H_WAIT;
            end
            H_WAIT: begin
               if (clr_cmd_rdy) cmd_rdy_reg <= 1'b0;
               if (leg_done) begin
                  if (indx == LAST_INDX) begin
                     tour_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     indx  <= indx + 5'd1;
                     state <= V_ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd     = (state == IDLE) ? cmd_UART     : cmd_reg;
   assign cmd_rdy = (state == IDLE) ? cmd_rdy_UART : cmd_rdy_reg;

endmodule
